// File: rtl/display_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : display_scan_driver
// Description : 8-digit multiplexed seven-segment driver (active-low) showing
//               the calculator display word and FSM state tag. Build option
//               DISPLAY_BCD_EN selects decimal (double-dabble) over hex.
// Revision    : 1.0 - initial release
// ============================================================================
module display_scan_driver #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic [2:0]  tag,
   input  logic        load,
   output logic        busy,
   output logic [7:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CONV   = 2'd1,
      S_COMMIT = 2'd2
   } state_t;

   localparam logic [15:0] c_RC_MAX = 16'(REFRESH_DIV - 1);

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_shadow_v;
   logic [2:0]  r_shadow_t;
   logic [15:0] r_pend_v;
   logic [2:0]  r_pend_t;
   logic        r_pend;
   logic [19:0] r_wrk;
   logic [19:0] r_disp;
   logic [2:0]  r_disp_t;
   logic [15:0] r_rc;
   logic [2:0]  r_di;
   logic [6:0]  w_seg;
   logic [4:1]  w_blank;
   logic        w_start;
   logic        w_take_pend;
   logic        w_capture;
   logic [15:0] w_src_v;
   logic [2:0]  w_src_t;
`ifdef DISPLAY_BCD_EN
   logic [3:0]  r_cnt;
   logic [19:0] w_adj;
`endif

   function automatic logic [6:0] f_glyph(input logic [3:0] i_n);
      case (i_n)
         4'h0: f_glyph = 7'h40;
         4'h1: f_glyph = 7'h79;
         4'h2: f_glyph = 7'h24;
         4'h3: f_glyph = 7'h30;
         4'h4: f_glyph = 7'h19;
         4'h5: f_glyph = 7'h12;
         4'h6: f_glyph = 7'h02;
         4'h7: f_glyph = 7'h78;
         4'h8: f_glyph = 7'h00;
         4'h9: f_glyph = 7'h10;
         4'hA: f_glyph = 7'h08;
         4'hB: f_glyph = 7'h03;
         4'hC: f_glyph = 7'h46;
         4'hD: f_glyph = 7'h21;
         4'hE: f_glyph = 7'h06;
         default: f_glyph = 7'h0E;
      endcase
   endfunction

   // ---------------- conversion FSM ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (load) w_next = S_CONV;
         S_CONV: begin
`ifdef DISPLAY_BCD_EN
            if (r_cnt == 4'd15) w_next = S_COMMIT;
`else
            w_next = S_COMMIT;
`endif
         end
         S_COMMIT: w_next = (r_pend || load) ? S_CONV : S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   assign busy = (r_state != S_IDLE);

   // A commit with a pending word restarts straight into CONV; a load landing
   // in that same cycle becomes the next pending word.
   assign w_take_pend = (r_state == S_COMMIT) && r_pend;
   assign w_start     = ((r_state == S_IDLE) && load) ||
                        ((r_state == S_COMMIT) && (r_pend || load));
   assign w_capture   = load && ((r_state == S_CONV) || w_take_pend);
   assign w_src_v     = w_take_pend ? r_pend_v : value;
   assign w_src_t     = w_take_pend ? r_pend_t : tag;

`ifdef DISPLAY_BCD_EN
   for (genvar gi = 0; gi < 5; gi++) begin : g_adj
      assign w_adj[4*gi +: 4] = (r_wrk[4*gi +: 4] >= 4'd5) ?
                                (r_wrk[4*gi +: 4] + 4'd3) : r_wrk[4*gi +: 4];
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_shadow_v <= 16'h0;
         r_shadow_t <= 3'h0;
         r_pend_v   <= 16'h0;
         r_pend_t   <= 3'h0;
         r_pend     <= 1'b0;
         r_wrk      <= 20'h0;
         r_disp     <= 20'h0;
         r_disp_t   <= 3'h0;
`ifdef DISPLAY_BCD_EN
         r_cnt      <= 4'h0;
`endif
      end else begin
         if (w_start) begin
            r_shadow_v <= w_src_v;
            r_shadow_t <= w_src_t;
            r_wrk      <= 20'h0;
`ifdef DISPLAY_BCD_EN
            r_cnt      <= 4'h0;
`endif
         end else if (r_state == S_CONV) begin
`ifdef DISPLAY_BCD_EN
            r_wrk      <= {w_adj[18:0], r_shadow_v[15]};
            r_shadow_v <= {r_shadow_v[14:0], 1'b0};
            r_cnt      <= r_cnt + 4'd1;
`else
            r_wrk      <= {4'h0, r_shadow_v};
`endif
         end

         if (w_capture) begin
            r_pend_v <= value;
            r_pend_t <= tag;
            r_pend   <= 1'b1;
         end else if (w_take_pend) begin
            r_pend   <= 1'b0;
         end

         if (r_state == S_COMMIT) begin
            r_disp   <= r_wrk;
            r_disp_t <= r_shadow_t;
         end
      end
   end

   // ---------------- scan ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rc <= 16'h0;
         r_di <= 3'h0;
      end else if (r_rc == c_RC_MAX) begin
         r_rc <= 16'h0;
         r_di <= r_di + 3'd1;
      end else begin
         r_rc <= r_rc + 16'd1;
      end
   end

   // Blank a digit in 1..4 only when it and all higher digits are zero.
   assign w_blank[4] = (r_disp[19:16] == 4'h0);
   assign w_blank[3] = w_blank[4] && (r_disp[15:12] == 4'h0);
   assign w_blank[2] = w_blank[3] && (r_disp[11:8]  == 4'h0);
   assign w_blank[1] = w_blank[2] && (r_disp[7:4]   == 4'h0);

   always_comb begin
      w_seg = 7'h7F;
      case (r_di)
         3'd0: w_seg = f_glyph(r_disp[3:0]);
         3'd1: if (!w_blank[1]) w_seg = f_glyph(r_disp[7:4]);
         3'd2: if (!w_blank[2]) w_seg = f_glyph(r_disp[11:8]);
         3'd3: if (!w_blank[3]) w_seg = f_glyph(r_disp[15:12]);
         3'd4: if (!w_blank[4]) w_seg = f_glyph(r_disp[19:16]);
         3'd7: w_seg = f_glyph({1'b0, r_disp_t});
         default: w_seg = 7'h7F;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         an  <= 8'hFF;
         seg <= 7'h7F;
      end else begin
         an  <= ~(8'd1 << r_di);
         seg <= w_seg;
      end
   end

   assign dp = 1'b1;

endmodule
`default_nettype wire
